// File: rtl/if_fetch_unit.sv
// if_fetch_unit -- instruction-fetch stage feeding the IF/ID pipeline register.
//
// Owns the PC and issues in-order word fetches over a valid/ready request
// channel. Responses return in request order and are held in a BUF_DEPTH-entry
// FIFO whose head is presented as pc_out / instruction_out / pc_plus_4_out.
// A taken branch flushes the FIFO and drops any responses still in flight for
// the old path (DRAIN state) before fetching from the new target.
//
// Parameters:
//   RESET_PC   PC loaded on reset
//   BUF_DEPTH  FIFO entries and maximum outstanding requests (power of 2, >= 2)
//
// Ports:
//   clk, reset                  clock; synchronous active-high reset
//   imem_req_valid/ready/addr   request channel to instruction memory
//   imem_resp_valid/data        in-order response channel (never back-pressured)
//   IF_IDWrite                  downstream accepts the presented instruction (0 = stall)
//   do_branch, branch_target    single-cycle taken-branch redirect
//   fetch_valid                 outputs hold a real instruction
//   pc_out, instruction_out, pc_plus_4_out   presented fetch triple
//
// Optional build macro FETCH_PERF_CNT_EN adds saturating counters:
//   perf_stall_cycles  cycles with fetch_valid && !IF_IDWrite
//   perf_flushed       FIFO entries flushed plus wrong-path responses dropped
module if_fetch_unit #(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter int unsigned BUF_DEPTH = 2
) (
  input  logic        clk,
  input  logic        reset,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  input  logic        IF_IDWrite,
  input  logic        do_branch,
  input  logic [31:0] branch_target,
  output logic        fetch_valid,
  output logic [31:0] pc_out,
  output logic [31:0] instruction_out,
  output logic [31:0] pc_plus_4_out
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [31:0] perf_stall_cycles,
  output logic [31:0] perf_flushed
`endif
);

  localparam int unsigned   AW      = $clog2(BUF_DEPTH);
  localparam int unsigned   CW      = AW + 1;
  localparam logic [CW-1:0] DEPTH_C = CW'(BUF_DEPTH);
  localparam logic [31:0]   NOP     = 32'h0000_0013;

  typedef enum logic {FETCH, DRAIN} state_t;

  state_t        state_q, state_d;
  logic [31:0]   pc_q, pc_d;
  logic          post_reset_q;
  logic [31:0]   last_pc_q;

  logic [31:0]   fifo_addr [BUF_DEPTH];
  logic [31:0]   fifo_data [BUF_DEPTH];
  logic [AW-1:0] rd_ptr_q, rd_ptr_d, wr_ptr_q, wr_ptr_d;
  logic [CW-1:0] count_q, count_d;

  // Addresses of accepted-but-unanswered requests, oldest first.
  logic [31:0]   aq_addr [BUF_DEPTH];
  logic [AW-1:0] aq_rd_q, aq_rd_d, aq_wr_q, aq_wr_d;
  logic [CW-1:0] outstanding_q, outstanding_d;
  logic [CW-1:0] stale_q, stale_d;

  logic [CW:0]   occupancy;
  logic          handshake, resp_live, push, pop, aq_push;

  // A response in the first cycle after reset belongs to a pre-reset request.
  always_comb begin
    occupancy      = {1'b0, count_q} + {1'b0, outstanding_q};
    imem_req_valid = (state_q == FETCH) && !post_reset_q && (occupancy < {1'b0, DEPTH_C});
    imem_req_addr  = pc_q;
    handshake      = imem_req_valid && imem_req_ready;
    resp_live      = imem_resp_valid && !post_reset_q;
  end

  always_comb begin
    state_d       = state_q;
    pc_d          = pc_q;
    stale_d       = stale_q;
    outstanding_d = outstanding_q;
    count_d       = count_q;
    rd_ptr_d      = rd_ptr_q;
    wr_ptr_d      = wr_ptr_q;
    aq_rd_d       = aq_rd_q;
    aq_wr_d       = aq_wr_q;
    push          = 1'b0;
    pop           = 1'b0;
    aq_push       = 1'b0;
    case (state_q)
      FETCH: begin
        if (do_branch) begin
          // Everything in flight, including a request accepted this very
          // cycle, is wrong-path; a response arriving now retires one of them.
          pc_d          = branch_target & 32'hFFFF_FFFC;
          stale_d       = outstanding_q + CW'(handshake)
                          - CW'(resp_live && (outstanding_q != '0));
          outstanding_d = '0;
          count_d       = '0;
          rd_ptr_d      = '0;
          wr_ptr_d      = '0;
          aq_rd_d       = '0;
          aq_wr_d       = '0;
          if (stale_d != '0) state_d = DRAIN;
        end else begin
          push    = resp_live && (outstanding_q != '0);
          pop     = (count_q != '0) && IF_IDWrite;
          aq_push = handshake;
          if (handshake) begin
            pc_d    = pc_q + 32'd4;
            aq_wr_d = aq_wr_q + AW'(1);
          end
          if (push) begin
            aq_rd_d  = aq_rd_q + AW'(1);
            wr_ptr_d = wr_ptr_q + AW'(1);
          end
          if (pop) rd_ptr_d = rd_ptr_q + AW'(1);
          outstanding_d = outstanding_q + CW'(handshake) - CW'(push);
          count_d       = count_q + CW'(push) - CW'(pop);
        end
      end
      DRAIN: begin
        if (stale_q == '0) state_d = FETCH;
        else if (resp_live) stale_d = stale_q - CW'(1);
        if (do_branch) pc_d = branch_target & 32'hFFFF_FFFC;
      end
      default: state_d = FETCH;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q       <= FETCH;
      pc_q          <= RESET_PC;
      post_reset_q  <= 1'b1;
      last_pc_q     <= '0;
      rd_ptr_q      <= '0;
      wr_ptr_q      <= '0;
      count_q       <= '0;
      aq_rd_q       <= '0;
      aq_wr_q       <= '0;
      outstanding_q <= '0;
      stale_q       <= '0;
    end else begin
      state_q       <= state_d;
      pc_q          <= pc_d;
      post_reset_q  <= 1'b0;
      rd_ptr_q      <= rd_ptr_d;
      wr_ptr_q      <= wr_ptr_d;
      count_q       <= count_d;
      aq_rd_q       <= aq_rd_d;
      aq_wr_q       <= aq_wr_d;
      outstanding_q <= outstanding_d;
      stale_q       <= stale_d;
      // Remember the head so an empty FIFO keeps showing the last PC.
      if (count_q != '0) last_pc_q <= fifo_addr[rd_ptr_q];
    end
  end

  always_ff @(posedge clk) begin
    if (!reset && push) begin
      fifo_addr[wr_ptr_q] <= aq_addr[aq_rd_q];
      fifo_data[wr_ptr_q] <= imem_resp_data;
    end
    if (!reset && aq_push) aq_addr[aq_wr_q] <= pc_q;
  end

  always_comb begin
    fetch_valid     = (count_q != '0);
    pc_out          = fetch_valid ? fifo_addr[rd_ptr_q] : last_pc_q;
    instruction_out = fetch_valid ? fifo_data[rd_ptr_q] : NOP;
    pc_plus_4_out   = pc_out + 32'd4;
  end

`ifdef FETCH_PERF_CNT_EN
  logic [32:0] flushed_sum;

  always_comb begin
    flushed_sum = {1'b0, perf_flushed};
    if (state_q == FETCH && do_branch)
      flushed_sum = flushed_sum + 33'(count_q) + 33'(resp_live && (outstanding_q != '0));
    else if (state_q == DRAIN && resp_live && (stale_q != '0))
      flushed_sum = flushed_sum + 33'd1;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      perf_stall_cycles <= '0;
      perf_flushed      <= '0;
    end else begin
      if (fetch_valid && !IF_IDWrite && (perf_stall_cycles != '1))
        perf_stall_cycles <= perf_stall_cycles + 32'd1;
      perf_flushed <= flushed_sum[32] ? '1 : flushed_sum[31:0];
    end
  end
`endif

  assert property (@(posedge clk) disable iff (reset)
                   occupancy <= {1'b0, DEPTH_C});
  assert property (@(posedge clk) disable iff (reset || post_reset_q)
                   imem_resp_valid |-> ((outstanding_q != '0) || (stale_q != '0)));

endmodule

// File: tb/tb_if_fetch_unit.sv
module tb_if_fetch_unit;
  localparam int unsigned DEPTH = 2;
  localparam logic [31:0] RPC   = 32'h0000_0100;
  localparam logic [31:0] NOP   = 32'h0000_0013;

  logic        clk = 1'b0;
  logic        reset;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_req_addr;
  logic        imem_resp_valid;
  logic [31:0] imem_resp_data;
  logic        IF_IDWrite;
  logic        do_branch;
  logic [31:0] branch_target;
  logic        fetch_valid;
  logic [31:0] pc_out;
  logic [31:0] instruction_out;
  logic [31:0] pc_plus_4_out;

  always #5 clk = ~clk;

  if_fetch_unit #(.RESET_PC(RPC), .BUF_DEPTH(DEPTH)) dut (
    .clk(clk), .reset(reset),
    .imem_req_valid(imem_req_valid), .imem_req_ready(imem_req_ready),
    .imem_req_addr(imem_req_addr),
    .imem_resp_valid(imem_resp_valid), .imem_resp_data(imem_resp_data),
    .IF_IDWrite(IF_IDWrite), .do_branch(do_branch), .branch_target(branch_target),
    .fetch_valid(fetch_valid), .pc_out(pc_out),
    .instruction_out(instruction_out), .pc_plus_4_out(pc_plus_4_out)
  );

  typedef struct packed { logic [31:0] addr; logic [31:0] data; } fent_t;
  typedef struct packed { int due; logic [31:0] addr; } ment_t;

  // Reference model: what the fetch stage must hold, as plain queues.
  fent_t       m_fifo[$];
  logic [31:0] m_outq[$];
  logic [31:0] m_pc, m_last;
  int          m_stale;
  bit          m_drain, m_post;

  // Memory environment.
  ment_t memq[$];
  int    mem_lat;
  bit    inj_resp;

  int cyc, n_checks, n_fail;
  bit started;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return ~a ^ 32'h0F00_0000;
  endfunction

  function automatic bit exp_req_valid();
    return !m_post && !m_drain && ((m_fifo.size() + m_outq.size()) < DEPTH);
  endfunction

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s (cycle %0d): actual %h required %h", name, cyc, act, exp);
    end
  endtask

  task automatic compare();
    bit          rv;
    logic [31:0] epc;
    rv = exp_req_valid();
    chk("imem_req_valid", 32'(imem_req_valid), 32'(rv));
    if (rv) chk("imem_req_addr", imem_req_addr, m_pc);
    chk("fetch_valid", 32'(fetch_valid), 32'(m_fifo.size() > 0));
    epc = (m_fifo.size() > 0) ? m_fifo[0].addr : m_last;
    chk("pc_out", pc_out, epc);
    chk("pc_plus_4_out", pc_plus_4_out, epc + 32'd4);
    chk("instruction_out", instruction_out, (m_fifo.size() > 0) ? m_fifo[0].data : NOP);
  endtask

  task automatic model_step();
    bit          hs, rv_eff, used;
    logic [31:0] a;
    hs = exp_req_valid() && imem_req_ready;
    if (reset) begin
      m_fifo.delete(); m_outq.delete();
      m_pc = RPC; m_last = '0; m_stale = 0; m_drain = 0; m_post = 1;
      return;
    end
    if (m_fifo.size() > 0) m_last = m_fifo[0].addr;
    rv_eff = imem_resp_valid && !m_post;
    m_post = 0;
    if (m_drain) begin
      if (m_stale == 0) m_drain = 0;
      else if (rv_eff) m_stale--;
      if (do_branch) m_pc = branch_target & 32'hFFFF_FFFC;
    end else if (do_branch) begin
      used    = rv_eff && (m_outq.size() > 0);
      m_stale = int'(m_outq.size()) + int'(hs) - int'(used);
      m_outq.delete(); m_fifo.delete();
      m_pc    = branch_target & 32'hFFFF_FFFC;
      m_drain = (m_stale != 0);
    end else begin
      if (m_fifo.size() > 0 && IF_IDWrite) void'(m_fifo.pop_front());
      if (rv_eff && m_outq.size() > 0) begin
        a = m_outq.pop_front();
        m_fifo.push_back('{addr: a, data: imem_resp_data});
      end
      if (hs) begin
        m_outq.push_back(m_pc);
        m_pc = m_pc + 32'd4;
      end
    end
  endtask

  // One clock cycle: drive the memory response, check, advance model and memory.
  task automatic tick();
    ment_t e;
    imem_resp_valid = 1'b0;
    imem_resp_data  = '0;
    if (inj_resp) begin
      imem_resp_valid = 1'b1;
      imem_resp_data  = 32'hBAD0_0001;
      inj_resp        = 0;
    end else if (memq.size() > 0 && memq[0].due <= cyc) begin
      e = memq.pop_front();
      imem_resp_valid = 1'b1;
      imem_resp_data  = mem_word(e.addr);
    end
    #1;
    if (started) compare();
    if (reset) memq.delete();
    else if (imem_req_valid && imem_req_ready)
      memq.push_back('{due: cyc + mem_lat, addr: imem_req_addr});
    model_step();
    if (reset) started = 1;
    @(negedge clk);
    cyc++;
  endtask

  task automatic reset_literals(input string tag);
    chk({tag, " req_valid"}, 32'(imem_req_valid), 32'd0);
    chk({tag, " fetch_valid"}, 32'(fetch_valid), 32'd0);
    chk({tag, " pc_out"}, pc_out, 32'h0000_0000);
    chk({tag, " pc_plus_4"}, pc_plus_4_out, 32'h0000_0004);
    chk({tag, " instruction"}, instruction_out, 32'h0000_0013);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: actual timeout required finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    bit found;
    reset = 1'b1; imem_req_ready = 1'b1; IF_IDWrite = 1'b1;
    do_branch = 1'b0; branch_target = '0;
    imem_resp_valid = 1'b0; imem_resp_data = '0;
    mem_lat = 1; inj_resp = 0; cyc = 0; n_checks = 0; n_fail = 0; started = 0;

    // Reset and streaming from RESET_PC.
    tick(); tick();
    reset_literals("reset");
    reset = 1'b0;
    for (int k = 0; k < 10 && !fetch_valid; k++) tick();
    chk("first pc_out", pc_out, 32'h0000_0100);
    chk("first pc_plus_4", pc_plus_4_out, 32'h0000_0104);
    chk("first instruction", instruction_out, 32'hF0FF_FEFF);
    for (int k = 0; k < 8; k++) tick();

    // Downstream stall, then release.
    IF_IDWrite = 1'b0;
    for (int k = 0; k < 5; k++) tick();
    chk("stall head valid", 32'(fetch_valid), 32'd1);
    IF_IDWrite = 1'b1;
    for (int k = 0; k < 6; k++) tick();

    // Memory not ready: FIFO drains, address held.
    imem_req_ready = 1'b0;
    for (int k = 0; k < 3; k++) tick();
    chk("not-ready drained", 32'(fetch_valid), 32'd0);
    chk("not-ready req_valid", 32'(imem_req_valid), 32'd1);
    tick();
    imem_req_ready = 1'b1;
    for (int k = 0; k < 6; k++) tick();

    // Redirect with two requests outstanding, 3-cycle memory.
    imem_req_ready = 1'b0;
    for (int k = 0; k < 4; k++) tick();
    mem_lat = 3; imem_req_ready = 1'b1;
    for (int k = 0; k < 10 && m_outq.size() != 2; k++) tick();
    do_branch = 1'b1; branch_target = 32'h0000_2002;
    tick();
    do_branch = 1'b0;
    n = 0;
    while (!imem_req_valid && n < 10) begin n++; tick(); end
    chk("drain cycles", 32'(n), 32'd3);
    chk("redirect addr", imem_req_addr, 32'h0000_2000);
    for (int k = 0; k < 12 && !fetch_valid; k++) tick();
    chk("redirect pc_out", pc_out, 32'h0000_2000);

    // Redirect coinciding with a response and a pop.
    found = 0;
    for (int k = 0; k < 20; k++) begin
      if (m_fifo.size() > 0 && memq.size() > 0 && memq[0].due <= cyc) begin
        found = 1;
        break;
      end
      tick();
    end
    chk("resp+pop cycle reached", 32'(found), 32'd1);
    do_branch = 1'b1; branch_target = 32'h0000_3000;
    tick();
    do_branch = 1'b0;
    chk("flush fetch_valid", 32'(fetch_valid), 32'd0);
    for (int k = 0; k < 8; k++) tick();

    // PC wrap at the top of the address space.
    mem_lat = 1;
    do_branch = 1'b1; branch_target = 32'hFFFF_FFFC;
    tick();
    do_branch = 1'b0;
    for (int k = 0; k < 30 && !fetch_valid; k++) tick();
    chk("wrap pc_out", pc_out, 32'hFFFF_FFFC);
    chk("wrap pc_plus_4", pc_plus_4_out, 32'h0000_0000);
    for (int k = 0; k < 6; k++) tick();

    // Reset in the middle of a drain; a late response is ignored.
    mem_lat = 3;
    for (int k = 0; k < 10 && m_outq.size() != 2; k++) tick();
    do_branch = 1'b1; branch_target = 32'h0000_4000;
    tick();
    do_branch = 1'b0;
    chk("drain req_valid", 32'(imem_req_valid), 32'd0);
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    reset_literals("mid-drain reset");
    mem_lat = 1; inj_resp = 1;
    for (int k = 0; k < 10 && !fetch_valid; k++) tick();
    chk("post-reset pc_out", pc_out, 32'h0000_0100);
    chk("post-reset instruction", instruction_out, 32'hF0FF_FEFF);
    for (int k = 0; k < 5; k++) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
